// File: rtl/pc_stage_pkg.sv
// Shared constants for the fetch-PC stage: reset vector, exception vector
// base, sequential step, and the redirect-source encoding used by pc_stage.
package pc_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] EXC_VEC_BASE     = 32'hBFC0_0380;
  localparam logic [31:0] PC_STEP          = 32'd4;

  // Which rule picked the next PC this cycle, highest priority first.
  typedef enum logic [2:0] {
    SrcExc,
    SrcPend,
    SrcBrHold,
    SrcBr,
    SrcSeq,
    SrcHold
  } pc_src_e;

  // Sequential successor; wraps modulo 2^32 by construction.
  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/pc_stage.sv
// Fetch address generator. Holds the architectural fetch PC, steps it on
// each accepted request, and applies decode branch redirects (with MIPS
// delay-slot ordering) and writeback exception/ERET redirects.
module pc_stage
  import pc_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  input  logic        br_valid,
  input  logic [31:0] br_pc,
  input  logic [31:0] br_target,
  input  logic        exc_valid,
  input  logic [31:0] exc_target,
  output logic        cancel_o
);

  logic [31:0] pc_q, pc_d;
  logic        valid_q;
  logic        pend_q, pend_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic        accept;
  logic [31:0] ds_pc;
  pc_src_e     src;

  // A request only counts as accepted while it is actually being presented.
  assign accept   = ready_i & valid_q;
  assign ds_pc    = br_pc + PC_STEP;
  assign pc_o     = pc_q;
  assign valid_o  = valid_q;
  assign cancel_o = exc_valid;

  // Pick the redirect source by priority.
  always_comb begin
    src = SrcHold;
    if (exc_valid) begin
      src = SrcExc;
    end else if (accept && pend_q) begin
      src = SrcPend;
    end else if (br_valid) begin
      // Delay slot still waiting to be accepted: park the target until it goes.
      src = ((pc_q == ds_pc) && !accept) ? SrcBrHold : SrcBr;
    end else if (accept) begin
      src = SrcSeq;
    end
  end

  // Next-state for the PC and the one-entry pending-redirect buffer.
  always_comb begin
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    unique case (src)
      SrcExc: begin
        pc_d   = exc_target;
        pend_d = 1'b0;
      end
      SrcPend: begin
        pc_d   = pend_tgt_q;
        pend_d = 1'b0;
      end
      SrcBrHold: begin
        pend_d     = 1'b1;
        pend_tgt_d = br_target;
      end
      SrcBr:   pc_d = br_target;
      SrcSeq:  pc_d = seq_pc(pc_q);
      SrcHold: pc_d = pc_q;
      default: pc_d = pc_q;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      pend_q     <= 1'b0;
      pend_tgt_q <= 32'h0;
    end else begin
      pc_q       <= pc_d;
      valid_q    <= 1'b1;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

endmodule
